sample_stream_buffer: RTL and testbench

//  Parametrised sample ring buffer between the mixer (producer, system clk) and the DAC /

---
 rtl/sample_stream_buffer.sv | 169 ++++++++++++++++
 tb/tb_sample_stream_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_stream_buffer.sv
// Sample ring buffer between the mixer and the DAC / Avalon-ST output. It prefills, then
// pops one sample per sample-rate tick. An Avalon-MM slave provides control and status.
module sample_stream_buffer #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned PREFILL  = 64,
  parameter int unsigned TICK_DIV = 521
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [DATA_W-1:0] o_dac_sample,
  output logic              o_tick,
  output logic [31:0]       aso_data,
  output logic              aso_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PREFILL = 2'd1, S_RUN = 2'd2} state_t;

  state_t            r_state, w_state_next;
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_tick_cnt;
  logic              r_tick, r_enable, r_underrun, r_aso_valid;
  logic [15:0]       r_underrun_cnt;
  logic [DATA_W-1:0] r_dac;
  logic [31:0]       r_aso_data, r_readdata;

  logic        w_ctrl_wr, w_status_wr, w_unrn_wr, w_enable_next, w_flush;
  logic        w_full, w_empty, w_accept, w_drain, w_push, w_pop, w_underflow;
  logic [31:0] w_status, w_rdata;
  logic        w_unused;

  assign w_ctrl_wr     = avs_write & (avs_address == 2'd0);
  assign w_status_wr   = avs_write & (avs_address == 2'd1);
  assign w_unrn_wr     = avs_write & (avs_address == 2'd2);
  assign w_enable_next = w_ctrl_wr ? avs_writedata[0] : r_enable;
  // Disabling also flushes, and a flush discards any same-cycle push or pop.
  assign w_flush       = (w_ctrl_wr & avs_writedata[1]) | ~w_enable_next;

  assign w_full      = (r_level == LW'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign o_ready     = w_accept & ~w_full;
  assign w_push      = i_valid & o_ready & ~w_flush;
  assign w_pop       = r_tick & w_drain & ~w_empty & ~w_flush;
  assign w_underflow = r_tick & w_drain & w_empty & ~w_flush;
  assign w_unused    = &{1'b0, avs_writedata[31:19], avs_writedata[17:2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!w_enable_next) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_next = S_PREFILL;
        S_PREFILL: if (!w_flush && r_level >= LW'(PREFILL)) w_state_next = S_RUN;
        S_RUN:     if (w_flush) w_state_next = S_PREFILL;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_accept = 1'b0;
    w_drain  = 1'b0;
    case (r_state)
      S_PREFILL: w_accept = 1'b1;
      S_RUN:     begin w_accept = 1'b1; w_drain = 1'b1; end
      default:   ;
    endcase
  end

  // Free-running sample-rate tick; r_tick is high while the counter sits at TICK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick_cnt <= (r_tick_cnt == CW'(TICK_DIV - 1)) ? '0 : r_tick_cnt + CW'(1);
      r_tick     <= (r_tick_cnt == CW'(TICK_DIV - 2));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_sample;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_enable       <= 1'b0;
      r_dac          <= '0;
      r_aso_data     <= '0;
      r_aso_valid    <= 1'b0;
      r_underrun_cnt <= '0;
      r_underrun     <= 1'b0;
    end else begin
      r_enable <= w_enable_next;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
      if (!w_enable_next) begin
        r_dac      <= '0;
        r_aso_data <= '0;
      end else if (w_pop) begin
        r_dac      <= r_mem[r_rd_ptr];
        r_aso_data <= 32'($signed(r_mem[r_rd_ptr]));
      end
      r_aso_valid <= w_pop | w_underflow;
      if (w_unrn_wr)                                 r_underrun_cnt <= '0;
      else if (w_underflow && r_underrun_cnt != '1)  r_underrun_cnt <= r_underrun_cnt + 16'd1;
      if (w_underflow)                               r_underrun <= 1'b1;
      else if (w_status_wr && avs_writedata[18])     r_underrun <= 1'b0;
    end
  end

  always_comb begin
    w_status         = '0;
    w_status[AW:0]   = r_level;
    w_status[16]     = w_full;
    w_status[17]     = w_empty;
    w_status[18]     = r_underrun;
    w_status[21:20]  = r_state;
    w_rdata          = '0;
    case (avs_address)
      2'd0:    w_rdata[0]     = r_enable;
      2'd1:    w_rdata        = w_status;
      2'd2:    w_rdata[15:0]  = r_underrun_cnt;
      default: w_rdata        = {8'd0, 8'(DATA_W), 16'(DEPTH)};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_readdata <= '0;
    else if (avs_read) r_readdata <= w_rdata;
  end

  assign avs_readdata = r_readdata;
  assign o_dac_sample = r_dac;
  assign o_tick       = r_tick;
  assign aso_data     = r_aso_data;
  assign aso_valid    = r_aso_valid;

endmodule

// File: tb/tb_sample_stream_buffer.sv
// Bench for sample_stream_buffer: directed phases with random sample data, checked every
// cycle against a queue-based reference model of the buffer.
module tb_sample_stream_buffer;
  localparam int unsigned DATA_W   = 24;
  localparam int unsigned DEPTH    = 128;
  localparam int unsigned PREFILL  = 64;
  localparam int unsigned TICK_DIV = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] i_sample;
  logic              i_valid;
  logic              o_ready;
  logic [1:0]        avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic [DATA_W-1:0] o_dac_sample;
  logic              o_tick;
  logic [31:0]       aso_data;
  logic              aso_valid;

  always #5 clk = ~clk;

  sample_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PREFILL(PREFILL), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .i_sample(i_sample), .i_valid(i_valid), .o_ready(o_ready),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .o_dac_sample(o_dac_sample),
    .o_tick(o_tick), .aso_data(aso_data), .aso_valid(aso_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the buffer contents are a queue, the rest is plain bookkeeping.
  logic [DATA_W-1:0] q[$];
  int unsigned       m_state, m_cnt, m_unrn;
  bit                m_enable, m_sticky, m_aso_valid;
  logic [DATA_W-1:0] m_dac;
  logic [31:0]       m_aso_data, m_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0; m_cnt = 0; m_unrn = 0; m_enable = 0; m_sticky = 0; m_aso_valid = 0;
    m_dac = '0; m_aso_data = '0; m_rdata = '0;
  endtask

  function automatic logic [31:0] reg_value(input logic [1:0] a);
    logic [31:0] v;
    int unsigned sz;
    v  = '0;
    sz = q.size();
    case (a)
      2'd0: v[0] = m_enable;
      2'd1: begin
        v[7:0] = 8'(sz); v[16] = (sz == DEPTH); v[17] = (sz == 0);
        v[18] = m_sticky; v[21:20] = 2'(m_state);
      end
      2'd2: v[15:0] = 16'(m_unrn);
      default: v = 32'(DEPTH) | (32'(DATA_W) << 16);
    endcase
    return v;
  endfunction

  task automatic step();
    bit ctrl_wr, en_next, flush, ready, tick, push, pop, unf;
    int unsigned sz;
    logic [31:0] rd;
    sz    = q.size();
    ready = (m_state != 0) && (sz < DEPTH);
    chk("o_ready", 32'(o_ready), 32'(ready));
    tick    = (m_cnt == TICK_DIV - 1);
    rd      = reg_value(avs_address);
    ctrl_wr = avs_write && (avs_address == 2'd0);
    en_next = ctrl_wr ? avs_writedata[0] : m_enable;
    flush   = (ctrl_wr && avs_writedata[1]) || !en_next;
    push    = i_valid && ready && !flush;
    pop     = tick && (m_state == 2) && !flush && (sz > 0);
    unf     = tick && (m_state == 2) && !flush && (sz == 0);
    @(posedge clk);
    if (!en_next)                        m_state = 0;
    else if (m_state == 0)               m_state = 1;
    else if (flush)                      m_state = 1;
    else if (m_state == 1 && sz >= PREFILL) m_state = 2;
    m_aso_valid = pop || unf;
    if (!en_next) begin
      m_dac = '0; m_aso_data = '0;
    end else if (pop) begin
      m_dac = q.pop_front(); m_aso_data = 32'($signed(m_dac));
    end
    if (push)  q.push_back(i_sample);
    if (flush) q.delete();
    if (avs_write && avs_address == 2'd2) m_unrn = 0;
    else if (unf && m_unrn < 65535)      m_unrn++;
    if (unf) m_sticky = 1;
    else if (avs_write && avs_address == 2'd1 && avs_writedata[18]) m_sticky = 0;
    if (avs_read) m_rdata = rd;
    m_enable = en_next;
    m_cnt    = (m_cnt + 1) % TICK_DIV;
    @(negedge clk);
    chk("o_tick", 32'(o_tick), 32'(m_cnt == TICK_DIV - 1));
    chk("o_dac_sample", 32'(o_dac_sample), 32'(m_dac));
    chk("aso_valid", 32'(aso_valid), 32'(m_aso_valid));
    chk("aso_data", aso_data, m_aso_data);
    chk("avs_readdata", avs_readdata, m_rdata);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    step();
    avs_write = 1'b0; avs_writedata = '0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    step();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 32'd0);
    chk({tag, "_dac"}, 32'(o_dac_sample), 32'd0);
    chk({tag, "_aso_valid"}, 32'(aso_valid), 32'd0);
    chk({tag, "_aso_data"}, aso_data, 32'd0);
    chk({tag, "_readdata"}, avs_readdata, 32'd0);
    chk({tag, "_tick"}, 32'(o_tick), 32'd0);
  endtask

  initial begin
    logic [31:0]       d;
    logic [DATA_W-1:0] last_fill;
    bit                seen, tk;
    int                guard;

    reset = 1'b1; i_sample = '0; i_valid = 1'b0;
    avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    reg_read(2'd3, d);  chk("config", d, 32'h0018_0080);
    reg_read(2'd1, d);  chk("status_idle", d, 32'h0002_0000);

    // Enable, prefill 1..64, then the first tick pops sample 1.
    reg_write(2'd0, 32'd1);
    for (int k = 1; k <= 64; k++) begin
      i_valid = 1'b1; i_sample = DATA_W'(k);
      step();
    end
    i_valid = 1'b0;
    reg_read(2'd1, d);  chk("status_prefill", {d[21:20], d[7:0]}, {2'd1, 8'd64});
    reg_read(2'd1, d);  chk("status_run", 32'(d[21:20]), 32'd2);
    seen = 0;
    for (int c = 0; c < 2 * TICK_DIV && !seen; c++) begin
      step();
      if (aso_valid) seen = 1;
    end
    chk("first_pop_seen", 32'(seen), 32'd1);
    chk("first_pop_dac", 32'(o_dac_sample), 32'd1);
    chk("first_pop_aso", aso_data, 32'h0000_0001);
    step();
    chk("aso_valid_pulse", 32'(aso_valid), 32'd0);

    // Fill to full with -5 first and random data after; pushes while full are dropped.
    i_valid = 1'b1; i_sample = 24'hFFFFFB;
    step();
    guard = 0;
    while (!(q.size() == DEPTH && m_cnt < TICK_DIV - 3) && guard < 3000) begin
      i_sample = DATA_W'($urandom);
      step();
      guard++;
    end
    chk("fill_reached_full", 32'(q.size()), 32'(DEPTH));
    chk("full_not_ready", 32'(o_ready), 32'd0);
    last_fill = q[q.size() - 1];
    i_sample  = 24'h0ABCDE;
    reg_read(2'd1, d);  chk("status_full", {d[17:16], d[7:0]}, {2'b01, 8'h80});
    reg_read(2'd1, d);  chk("status_full_hold", 32'(d[7:0]), 32'h80);
    i_valid = 1'b0;

    // Drain until three underruns; -5 must come out sign-extended.
    seen = 0; guard = 0;
    while (m_unrn < 3 && guard < (DEPTH + 8) * TICK_DIV) begin
      step();
      if (m_aso_valid && m_dac == 24'hFFFFFB && !seen) begin
        chk("neg5_aso", aso_data, 32'hFFFF_FFFB);
        seen = 1;
      end
      guard++;
    end
    chk("neg5_seen", 32'(seen), 32'd1);
    chk("dac_hold", 32'(o_dac_sample), 32'(last_fill));
    reg_read(2'd2, d);  chk("underrun_cnt3", d, 32'd3);
    reg_read(2'd1, d);  chk("status_sticky", 32'(d[18:17]), 32'd3);
    reg_write(2'd1, 32'h0004_0000);
    reg_read(2'd1, d);  chk("sticky_w1c", 32'(d[18]), 32'd0);

    // Hold level 10 with a push on every tick pop, long enough to wrap the ring.
    guard = 0;
    while (m_cnt != 0 && guard < TICK_DIV) begin step(); guard++; end
    reg_write(2'd2, 32'd0);
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1; i_sample = DATA_W'($urandom);
      step();
    end
    for (int t = 0; t < 300; ) begin
      tk = (m_cnt == TICK_DIV - 1);
      i_valid = tk; i_sample = DATA_W'($urandom);
      step();
      if (tk) t++;
    end
    i_valid = 1'b0;
    reg_read(2'd1, d);  chk("level_steady10", 32'(d[7:0]), 32'd10);
    reg_read(2'd2, d);  chk("no_underrun_steady", d, 32'd0);

    // Flush at level 50 (with a coincident push), then disable.
    guard = 0;
    while (q.size() != 50 && guard < 1000) begin
      i_valid = (q.size() < 50); i_sample = DATA_W'($urandom);
      step();
      guard++;
    end
    chk("level50_reached", 32'(q.size()), 32'd50);
    i_valid = 1'b1;
    reg_write(2'd0, 32'd3);
    i_valid = 1'b0;
    reg_read(2'd1, d);  chk("status_flushed", {d[21:20], d[17], d[7:0]}, {2'd1, 1'b1, 8'd0});
    reg_read(2'd0, d);  chk("ctrl_after_flush", d, 32'd1);
    reg_write(2'd0, 32'd0);
    chk("disable_dac", 32'(o_dac_sample), 32'd0);
    reg_read(2'd1, d);  chk("status_disabled", 32'(d[21:20]), 32'd0);

    // Re-enable, run with random traffic, then assert async reset mid-run.
    reg_write(2'd0, 32'd1);
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(0, 3) != 0); i_sample = DATA_W'($urandom);
      step();
    end
    chk("run_before_reset", 32'(m_state), 32'd2);
    i_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 100; c++) step();
    reg_read(2'd1, d);  chk("status_after_reset", d, 32'h0002_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
